leaf_accumulator: RTL
=====================

# leaf_accumulator

Consumer end of the CAM solver tree's match-leaf stream: accepts router output beats (matched leaf values plus class IDs), sums leaf values per class over a configurable number of beats per sample, then drains one per-class sum per beat on an AXI-stream master. Sits between the top-level `multi_core_cam_solver` instance (`match_leaves`/`match_class_ids`/`ml_valid`/`ml_ready`) and the kernel's result output stream.

## Interface
- NUM_ROUTER_OUTPUTS, 1: leaf lanes per input beat
- NUM_CLASSES, 2: per-class accumulators; 1 for binary classification
- LEAF_WIDTH, LEAF_VALUES_NUM_BITS: signed leaf width
- CLASS_WIDTH, CLASS_ID_NUM_BITS: class ID width
- ACC_WIDTH, 32: signed accumulator width, must be >= LEAF_WIDTH + $clog2(NUM_ROUTER_OUTPUTS)

Ports:
- clk  in  1  sole clock
- rst  in  1  asynchronous, active-low reset
- beats_per_sample  in  16  input beats per sample, sampled on the first beat of each sample; 0 treated as 1
- ml_valid  in  1  input beat valid
- ml_ready  out  1  input beat ready
- match_leaves  in  NUM_ROUTER_OUTPUTS x LEAF_WIDTH  signed leaf per lane
- match_class_ids  in  NUM_ROUTER_OUTPUTS x CLASS_WIDTH  class per lane
- m_axis_tdata  out  ACC_WIDTH  class sum
- m_axis_tuser  out  $clog2(NUM_CLASSES) (min 1)  class index of this beat
- m_axis_tlast  out  1  high on class NUM_CLASSES-1
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  output ready
- samples_done  out  32  completed samples, wraps
- acc_overflow  out  1  sticky: signed overflow in any accumulation
- bad_class  out  1  sticky: lane class ID >= NUM_CLASSES

## Operation
- Two states: ACCUM, DRAIN. Reset state is ACCUM.
- ACCUM:
  - ml_ready = 1.
  - Each handshake (ml_valid & ml_ready) adds all lanes to acc[class_id], sign-extended to ACC_WIDTH.
  - Several lanes with the same class in one beat all add; the update is the sum of those lanes.
  - A lane with an out-of-range class is dropped and sets bad_class.
  - Beat counter increments per handshake. On the first beat (counter = 0), beats_per_sample is latched into bpp_q.
  - When the handshake makes counter = bpp_q: counter clears and the state goes to DRAIN.
- DRAIN:
  - ml_ready = 0.
  - Emits classes 0..NUM_CLASSES-1 in order, one per output handshake.
  - tdata = acc[idx], tuser = idx, tlast = (idx == NUM_CLASSES-1).
  - On the tlast handshake: all accumulators clear to 0, samples_done increments, state returns to ACCUM.
- Arithmetic:
  - Two's-complement add at ACC_WIDTH; the result wraps.
  - acc_overflow sets when the operands have the same sign and the result sign differs (evaluated per class over the full lane sum).
- Sticky flags clear only on reset.
- Reset mid-operation: accumulators, counter, idx, samples_done and flags clear; the state returns to ACCUM. A partially drained sample is lost.

## Timing
- Reset values:
  - ml_ready = 1
  - m_axis_tvalid = 0, m_axis_tdata = 0, m_axis_tuser = 0, m_axis_tlast = 0
  - samples_done = 0, acc_overflow = 0, bad_class = 0
- Accumulation latency: a beat accepted at cycle N is visible in acc at N+1.
- A final beat accepted at cycle N gives m_axis_tvalid = 1 at N+1 with class 0, carrying that beat's contribution.
- ml_ready is 0 from N+1 until the cycle after the tlast handshake.
- Outputs are registered: tvalid/tdata/tuser/tlast hold stable while tvalid & !tready.
- With tready held high, the drain takes exactly NUM_CLASSES cycles.
- Back-to-back sample throughput: bpp + NUM_CLASSES cycles per sample.
- ml_ready does not depend combinationally on ml_valid. No output depends combinationally on m_axis_tready except the advance on the next edge.
- bad_class/acc_overflow assert the cycle after the offending beat.

## Test plan
- Reset mid-drain:
  - Stimulus: NUM_CLASSES=2; sample with leaves 5 (class 0) and -3 (class 1); assert rst low during the class-0 beat with tready=0.
  - Response: all outputs return to reset values; the next sample sums from 0.
- Basic binary sample:
  - Stimulus: NUM_CLASSES=1, NUM_ROUTER_OUTPUTS=1, bpp=4, leaves 10, -2, 7, 0.
  - Response: one output beat, tdata=15, tlast=1, at the cycle after the 4th beat; samples_done=1.
- Multi-lane, multi-class:
  - Stimulus: NUM_ROUTER_OUTPUTS=2, NUM_CLASSES=3, bpp=2; beats {(4,c0),(6,c0)} and {(-1,c2),(9,c1)}.
  - Response: output beats (10,u0), (9,u1), (-1,u2,tlast); ml_ready=0 throughout the drain.
- Backpressure:
  - Stimulus: same as basic binary sample, with tready=0 for 5 cycles.
  - Response: tdata stays 15 and tvalid stays 1; ml_ready stays 0 while ml_valid is held high; the next sample starts only after the handshake.
- Overflow/bad class:
  - Stimulus: ACC_WIDTH=8; leaves 100 and 100 into class 0; separately, a lane with class ID 5 when NUM_CLASSES=2.
  - Response: tdata=-56 with acc_overflow=1; the class-5 lane is ignored and bad_class=1; both flags stay sticky.
- bpp=0 handling:
  - Stimulus: beats_per_sample=0.
  - Response: each beat produces its own drain (treated as bpp=1).

Source files
------------

// File: rtl/leaf_accumulator.sv
// leaf_accumulator: sums matched leaf values per class over a sample,
// then drains one class sum per beat on an AXI-stream master.
module leaf_accumulator #(
  parameter int NUM_ROUTER_OUTPUTS = 1,
  parameter int NUM_CLASSES = 2,
  parameter int LEAF_WIDTH = 16,
  parameter int CLASS_WIDTH = 8,
  parameter int ACC_WIDTH = 32,
  localparam int UW = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic [15:0] beats_per_sample,
  input  logic ml_valid,
  output logic ml_ready,
  input  logic [NUM_ROUTER_OUTPUTS*LEAF_WIDTH-1:0] match_leaves,
  input  logic [NUM_ROUTER_OUTPUTS*CLASS_WIDTH-1:0] match_class_ids,
  output logic [ACC_WIDTH-1:0] m_axis_tdata,
  output logic [UW-1:0] m_axis_tuser,
  output logic m_axis_tlast,
  output logic m_axis_tvalid,
  input  logic m_axis_tready,
  output logic [31:0] samples_done,
  output logic acc_overflow,
  output logic bad_class
);

  localparam logic ACCUM = 1'b0;
  localparam logic DRAIN = 1'b1;
  localparam logic [UW-1:0] LAST = UW'(NUM_CLASSES - 1);

  logic state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q [NUM_CLASSES];
  logic [ACC_WIDTH-1:0] acc_d [NUM_CLASSES];
  logic [ACC_WIDTH-1:0] lane_sum [NUM_CLASSES];
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] bpp_q, bpp_d;
  logic [15:0] bpp_eff;
  logic [UW-1:0] idx_q, idx_d;
  logic [31:0] done_q, done_d;
  logic ovf_q, ovf_d;
  logic bad_q, bad_d;
  logic bad_lane;
  logic ml_fire, out_fire;
  logic [CLASS_WIDTH-1:0] cls;
  logic [LEAF_WIDTH-1:0] leaf;

  assign ml_ready = (state_q == ACCUM);
  assign m_axis_tvalid = (state_q == DRAIN);
  assign ml_fire = ml_valid & ml_ready;
  assign out_fire = m_axis_tvalid & m_axis_tready;

  // Per-class sum of this beat's lanes; out-of-range lanes are dropped.
  always_comb begin
    bad_lane = 1'b0;
    cls = '0;
    leaf = '0;
    for (int c = 0; c < NUM_CLASSES; c++) lane_sum[c] = '0;
    for (int l = 0; l < NUM_ROUTER_OUTPUTS; l++) begin
      cls = match_class_ids[l*CLASS_WIDTH +: CLASS_WIDTH];
      leaf = match_leaves[l*LEAF_WIDTH +: LEAF_WIDTH];
      if (32'(cls) >= 32'(NUM_CLASSES)) bad_lane = 1'b1;
      for (int c = 0; c < NUM_CLASSES; c++) begin
        if (32'(cls) == 32'(c))
          lane_sum[c] = lane_sum[c] + ACC_WIDTH'($signed(leaf));
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    bpp_d = bpp_q;
    idx_d = idx_q;
    done_d = done_q;
    ovf_d = ovf_q;
    bad_d = bad_q;
    for (int c = 0; c < NUM_CLASSES; c++) acc_d[c] = acc_q[c];
    bpp_eff = bpp_q;
    if (cnt_q == 16'd0)
      bpp_eff = (beats_per_sample == 16'd0) ? 16'd1 : beats_per_sample;
    unique case (1'b1)
      ml_fire: begin
        bpp_d = bpp_eff;
        bad_d = bad_q | bad_lane;
        for (int c = 0; c < NUM_CLASSES; c++) begin
          acc_d[c] = acc_q[c] + lane_sum[c];
          if ((acc_q[c][ACC_WIDTH-1] == lane_sum[c][ACC_WIDTH-1]) &&
              (acc_d[c][ACC_WIDTH-1] != acc_q[c][ACC_WIDTH-1]))
            ovf_d = 1'b1;
        end
        if (cnt_q + 16'd1 == bpp_eff) begin
          cnt_d = 16'd0;
          state_d = DRAIN;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      out_fire: begin
        if (idx_q == LAST) begin
          idx_d = '0;
          state_d = ACCUM;
          done_d = done_q + 32'd1;
          for (int c = 0; c < NUM_CLASSES; c++) acc_d[c] = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ACCUM;
      cnt_q <= '0;
      bpp_q <= 16'd1;
      idx_q <= '0;
      done_q <= '0;
      ovf_q <= 1'b0;
      bad_q <= 1'b0;
      for (int c = 0; c < NUM_CLASSES; c++) acc_q[c] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      bpp_q <= bpp_d;
      idx_q <= idx_d;
      done_q <= done_d;
      ovf_q <= ovf_d;
      bad_q <= bad_d;
      for (int c = 0; c < NUM_CLASSES; c++) acc_q[c] <= acc_d[c];
    end
  end

  assign m_axis_tdata = m_axis_tvalid ? acc_q[idx_q] : '0;
  assign m_axis_tuser = idx_q;
  assign m_axis_tlast = m_axis_tvalid && (idx_q == LAST);
  assign samples_done = done_q;
  assign acc_overflow = ovf_q;
  assign bad_class = bad_q;

endmodule
